// File: rtl/ws_pkg.sv
// Shared constants and types for the weight-stationary systolic array slice.
package ws_pkg;

  localparam int WS_NUM_COLS   = 4;
  localparam int WS_DATA_WIDTH = 8;

  function automatic int ws_psum_width(input int data_width);
    return 2 * data_width;
  endfunction

  localparam int WS_PSUM_WIDTH = ws_psum_width(WS_DATA_WIDTH);

  // One aligned output row; element 0 is column 1.
  typedef logic [WS_NUM_COLS-1:0][WS_PSUM_WIDTH-1:0] ws_row_t;

endpackage

// File: rtl/ws_row_fifo.sv
// Parameterised synchronous FIFO with registered write and head-of-queue read.
// Push while full is refused unless a pop happens in the same cycle.
module ws_row_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push_ok && !pop_ok)      count_q <= count_q + CNT_ONE;
      else if (!push_ok && pop_ok) count_q <= count_q - CNT_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; entries are only visible through
  // the count, and rdata is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ws_output_collector.sv
// Realigns the staggered column psums of the 4x4 WS array into rows and queues them.
// Optional sticky drop flag o_overflow is built when WS_COLLECT_OVF_EN is defined.
module ws_output_collector
  import ws_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BASE_LAT   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clear,
  input  logic                    i_vec_valid,
  input  logic [2*DATA_WIDTH-1:0] i_p_col_1,
  input  logic [2*DATA_WIDTH-1:0] i_p_col_2,
  input  logic [2*DATA_WIDTH-1:0] i_p_col_3,
  input  logic [2*DATA_WIDTH-1:0] i_p_col_4,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [8*DATA_WIDTH-1:0] o_row
`ifdef WS_COLLECT_OVF_EN
  ,
  output logic                    o_overflow
`endif
);

  localparam int PSUM_W  = ws_psum_width(DATA_WIDTH);
  localparam int TAG_LEN = BASE_LAT + WS_NUM_COLS - 1;
  localparam int ROW_W   = WS_NUM_COLS * PSUM_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic [TAG_LEN-1:0]                 tag_q;
  logic [2:0][PSUM_W-1:0]             col1_q;
  logic [1:0][PSUM_W-1:0]             col2_q;
  logic [PSUM_W-1:0]                  col3_q;
  logic [WS_NUM_COLS-1:0][PSUM_W-1:0] row_aligned;
  logic                               push;
  logic                               pop;
  logic                               drop;
  logic                               fifo_full;
  logic                               fifo_empty;
  logic [CNT_W-1:0]                   fifo_count;
  logic [ROW_W-1:0]                   fifo_rdata;
  logic                               unused_sink;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          tag_q <= '0;
    else if (i_clear) tag_q <= '0;
    else              tag_q <= {tag_q[TAG_LEN-2:0], i_vec_valid};
  end

  // Deskew triangle: column c waits 4-c cycles so all columns meet at the last tag stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col1_q <= '0;
      col2_q <= '0;
      col3_q <= '0;
    end else begin
      col1_q <= {col1_q[1:0], i_p_col_1};
      col2_q <= {col2_q[0], i_p_col_2};
      col3_q <= i_p_col_3;
    end
  end

  assign row_aligned = {i_p_col_4, col3_q, col2_q[1], col1_q[2]};
  assign push        = tag_q[TAG_LEN-1];
  assign o_valid     = !fifo_empty;
  assign pop         = o_valid && i_ready;
  assign drop        = push && fifo_full && !pop;
  assign o_row       = fifo_rdata;

  ws_row_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (i_clear),
    .push  (push),
    .pop   (pop),
    .wdata (row_aligned),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef WS_COLLECT_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf_q <= 1'b0;
    else if (i_clear) ovf_q <= 1'b0;
    else if (drop)    ovf_q <= 1'b1;
  end

  assign o_overflow  = ovf_q;
  assign unused_sink = ^fifo_count;
`else
  assign unused_sink = ^{drop, fifo_count};
`endif

endmodule

// File: tb/tb_ws_output_collector.sv
// Directed self-checking bench for ws_output_collector (default parameters).
module tb_ws_output_collector;
  import ws_pkg::*;

  logic        clk;
  logic        rst;
  logic        i_clear;
  logic        i_vec_valid;
  logic [15:0] i_p_col_1;
  logic [15:0] i_p_col_2;
  logic [15:0] i_p_col_3;
  logic [15:0] i_p_col_4;
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_row;
`ifdef WS_COLLECT_OVF_EN
  logic        o_overflow;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  int      sched_t[$];
  ws_row_t sched_row[$];

  ws_output_collector #(
    .DATA_WIDTH (8),
    .BASE_LAT   (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (i_clear),
    .i_vec_valid (i_vec_valid),
    .i_p_col_1   (i_p_col_1),
    .i_p_col_2   (i_p_col_2),
    .i_p_col_3   (i_p_col_3),
    .i_p_col_4   (i_p_col_4),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_row       (o_row)
`ifdef WS_COLLECT_OVF_EN
    ,
    .o_overflow  (o_overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Column c (0-based) of a vector tagged in cycle t appears in cycle t+4+c; other cycles carry junk.
  task automatic drive_inputs();
    logic [3:0][15:0] cols;
    logic             vv;
    vv = 1'b0;
    for (int c = 0; c < 4; c++) cols[c] = 16'hA5A5 ^ 16'(cyc * 4 + c);
    foreach (sched_t[i]) begin
      if (sched_t[i] == cyc) vv = 1'b1;
      for (int c = 0; c < 4; c++)
        if (cyc == sched_t[i] + 4 + c) cols[c] = sched_row[i][c];
    end
    i_vec_valid = vv;
    i_p_col_1   = cols[0];
    i_p_col_2   = cols[1];
    i_p_col_3   = cols[2];
    i_p_col_4   = cols[3];
  endtask

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    cyc++;
    drive_inputs();
  endtask

  task automatic add_vec(input int t, input ws_row_t r);
    sched_t.push_back(t);
    sched_row.push_back(r);
  endtask

  task automatic flush();
    sched_t.delete();
    sched_row.delete();
    begin_cycle();
    i_clear = 1'b1;
    i_ready = 1'b0;
    begin_cycle();
    i_clear = 1'b0;
  endtask

  task automatic test_reset();
    n_total++;
    if (o_valid !== 1'b0) $display("FAIL reset_valid: o_valid=%0b expected 0", o_valid);
    else n_pass++;
    n_total++;
    if (o_row !== 64'h0) $display("FAIL reset_row: o_row=%h expected 0", o_row);
    else n_pass++;
`ifdef WS_COLLECT_OVF_EN
    n_total++;
    if (o_overflow !== 1'b0) $display("FAIL reset_ovf: o_overflow=%0b expected 0", o_overflow);
    else n_pass++;
`endif
    begin_cycle();
    rst = 1'b0;
    #4;
    n_total++;
    if (o_valid !== 1'b0) $display("FAIL post_reset_valid: o_valid=%0b expected 0", o_valid);
    else n_pass++;
  endtask

  task automatic test_single();
    int      t;
    ws_row_t exp_row;
    flush();
    t       = cyc + 1;
    exp_row = 64'h0044_0033_0022_0011;
    add_vec(t, exp_row);
    repeat (12) begin
      begin_cycle();
      i_ready = 1'b1;
      #4;
      n_total++;
      if (o_valid !== 1'(cyc == t + 8))
        $display("FAIL single_valid: cycle t+%0d o_valid=%0b expected %0b", cyc - t, o_valid, cyc == t + 8);
      else n_pass++;
      if (cyc == t + 8) begin
        n_total++;
        if (o_row !== exp_row) $display("FAIL single_row: o_row=%h expected %h", o_row, exp_row);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int      t;
    ws_row_t rows[4];
    flush();
    t       = cyc + 1;
    rows[0] = 64'h1004_1003_1002_1001;
    rows[1] = 64'h2004_2003_2002_2001;
    rows[2] = 64'h3004_3003_3002_3001;
    rows[3] = 64'h4004_4003_4002_4001;
    for (int v = 0; v < 4; v++) add_vec(t + v, rows[v]);
    repeat (14) begin
      begin_cycle();
      i_ready = 1'b1;
      #4;
      n_total++;
      if (o_valid !== 1'(cyc >= t + 8 && cyc <= t + 11))
        $display("FAIL b2b_valid: cycle t+%0d o_valid=%0b", cyc - t, o_valid);
      else n_pass++;
      if (cyc >= t + 8 && cyc <= t + 11) begin
        n_total++;
        if (o_row !== rows[cyc - t - 8])
          $display("FAIL b2b_row: cycle t+%0d o_row=%h expected %h", cyc - t, o_row, rows[cyc - t - 8]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    int      t;
    int      idx;
    ws_row_t rows[6];
    flush();
    t = cyc + 1;
    for (int v = 0; v < 6; v++) begin
      rows[v] = {16'(16'hA004 + 16'(v << 8)), 16'(16'hA003 + 16'(v << 8)),
                 16'(16'hA002 + 16'(v << 8)), 16'(16'hA001 + 16'(v << 8))};
      add_vec(t + v, rows[v]);
    end
    repeat (20) begin
      begin_cycle();
      i_ready = 1'(cyc >= t + 15);
      #4;
      n_total++;
      if (o_valid !== 1'(cyc >= t + 8 && cyc <= t + 18))
        $display("FAIL bp_valid: cycle t+%0d o_valid=%0b", cyc - t, o_valid);
      else n_pass++;
      if (cyc >= t + 8 && cyc <= t + 18) begin
        idx = (cyc <= t + 15) ? 0 : cyc - (t + 15);
        n_total++;
        if (o_row !== rows[idx])
          $display("FAIL bp_row: cycle t+%0d o_row=%h expected %h", cyc - t, o_row, rows[idx]);
        else n_pass++;
      end
`ifdef WS_COLLECT_OVF_EN
      if (cyc == t + 10 || cyc == t + 14) begin
        n_total++;
        if (o_overflow !== 1'(cyc == t + 14))
          $display("FAIL bp_ovf: cycle t+%0d o_overflow=%0b", cyc - t, o_overflow);
        else n_pass++;
      end
`endif
    end
  endtask

  task automatic test_full_push_pop();
    int      t;
    int      idx;
    ws_row_t rows[5];
    flush();
    t = cyc + 1;
    for (int v = 0; v < 5; v++) begin
      rows[v] = {16'(16'hF004 + 16'(v << 4)), 16'(16'hF003 + 16'(v << 4)),
                 16'(16'hF002 + 16'(v << 4)), 16'(16'hF001 + 16'(v << 4))};
      add_vec(t + v, rows[v]);
    end
    repeat (18) begin
      begin_cycle();
      i_ready = 1'((cyc == t + 11) || (cyc >= t + 13));
      #4;
      n_total++;
      if (o_valid !== 1'(cyc >= t + 8 && cyc <= t + 16))
        $display("FAIL fpp_valid: cycle t+%0d o_valid=%0b", cyc - t, o_valid);
      else n_pass++;
      if (cyc >= t + 8 && cyc <= t + 16) begin
        idx = (cyc <= t + 11) ? 0 : (cyc <= t + 13) ? 1 : cyc - (t + 12);
        n_total++;
        if (o_row !== rows[idx])
          $display("FAIL fpp_row: cycle t+%0d o_row=%h expected %h", cyc - t, o_row, rows[idx]);
        else n_pass++;
      end
    end
`ifdef WS_COLLECT_OVF_EN
    n_total++;
    if (o_overflow !== 1'b0) $display("FAIL fpp_ovf: o_overflow=%0b expected 0", o_overflow);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_midflight();
    int      t;
    ws_row_t r0;
    flush();
    t  = cyc + 1;
    r0 = 64'h0D04_0D03_0D02_0D01;
    add_vec(t, r0);
    add_vec(t + 6, 64'h0E04_0E03_0E02_0E01);
    add_vec(t + 7, 64'h0F04_0F03_0F02_0F01);
    repeat (10) begin
      begin_cycle();
      i_ready = 1'b0;
      #4;
    end
    n_total++;
    if (o_valid !== 1'b1 || o_row !== r0)
      $display("FAIL rst_pre: o_valid=%0b o_row=%h expected 1 %h", o_valid, o_row, r0);
    else n_pass++;
    #1;
    rst = 1'b1;
    #1;
    n_total++;
    if (o_valid !== 1'b0 || o_row !== 64'h0)
      $display("FAIL rst_async: o_valid=%0b o_row=%h expected 0 0", o_valid, o_row);
    else n_pass++;
    begin_cycle();
    rst = 1'b0;
    repeat (12) begin
      begin_cycle();
      i_ready = 1'b1;
      #4;
      n_total++;
      if (o_valid !== 1'b0) $display("FAIL rst_after: cycle t+%0d o_valid=%0b expected 0", cyc - t, o_valid);
      else n_pass++;
    end
  endtask

  task automatic test_clear_midflight();
    int      t;
    ws_row_t r0;
    flush();
    t  = cyc + 1;
    r0 = 64'hC004_C003_C002_C001;
    add_vec(t, r0);
    for (int v = 1; v < 5; v++) add_vec(t + v, 64'hC104_C103_C102_C101 + 64'(v));
    add_vec(t + 8, 64'hCE04_CE03_CE02_CE01);
    add_vec(t + 9, 64'hCF04_CF03_CF02_CF01);
    repeat (21) begin
      begin_cycle();
      i_clear = 1'(cyc == t + 12);
      i_ready = 1'b0;
      #4;
      if (cyc == t + 12) begin
        n_total++;
        if (o_valid !== 1'b1 || o_row !== r0)
          $display("FAIL clr_pre: o_valid=%0b o_row=%h expected 1 %h", o_valid, o_row, r0);
        else n_pass++;
`ifdef WS_COLLECT_OVF_EN
        n_total++;
        if (o_overflow !== 1'b1) $display("FAIL clr_pre_ovf: o_overflow=%0b expected 1", o_overflow);
        else n_pass++;
`endif
      end
      if (cyc == t + 13) begin
        n_total++;
        if (o_row !== 64'h0) $display("FAIL clr_row: o_row=%h expected 0", o_row);
        else n_pass++;
`ifdef WS_COLLECT_OVF_EN
        n_total++;
        if (o_overflow !== 1'b0) $display("FAIL clr_ovf: o_overflow=%0b expected 0", o_overflow);
        else n_pass++;
`endif
      end
      if (cyc >= t + 13) begin
        n_total++;
        if (o_valid !== 1'b0) $display("FAIL clr_after: cycle t+%0d o_valid=%0b expected 0", cyc - t, o_valid);
        else n_pass++;
      end
    end
    i_clear = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    i_clear     = 1'b0;
    i_ready     = 1'b0;
    i_vec_valid = 1'b0;
    i_p_col_1   = '0;
    i_p_col_2   = '0;
    i_p_col_3   = '0;
    i_p_col_4   = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full_push_pop();
    test_reset_midflight();
    test_clear_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
